// File: rtl/spi_packet_decode.sv
// rtl/spi_packet_decode.sv - 4-byte SPI paint packet decoder with checksum, range check and inter-byte timeout
// Outputs update only on a fully validated packet; partial fields live in shadow registers.
module spi_packet_decode #(
  parameter int X_MAX   = 640,
  parameter int Y_MAX   = 480,
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       byte_valid,
  input  logic [7:0] spi_byte,
  output logic       brush,
  output logic [2:0] newColor,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       ready,
  output logic       pkt_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    XLO  = 2'd2,
    YLO  = 2'd3
  } state_t;

  localparam logic [10:0] X_LIM  = 11'(X_MAX);
  localparam logic [10:0] Y_LIM  = 11'(Y_MAX);
  localparam logic [10:0] TO_LIM = 11'(TIMEOUT);
  localparam logic [2:0]  SYNC   = 3'b101;

  state_t      state_q, state_d;
  logic [10:0] gap_q, gap_d;
  logic [7:0]  b0_q, b0_d;
  logic [7:0]  xlo_q, xlo_d;
  logic [7:0]  ylo_q, ylo_d;
  logic        brush_q, brush_d;
  logic [2:0]  color_q, color_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        ready_q, ready_d;
  logic        pkt_err_q, pkt_err_d;

  // B3 is consumed straight off the input, so the final check combines it with the shadows.
  logic [3:0]  csum;
  logic [9:0]  x_full;
  logic [9:0]  y_full;
  logic        pkt_ok;
  logic [10:0] gap_inc;

  assign csum    = b0_q[7:4] ^ b0_q[3:0] ^ xlo_q[7:4] ^ xlo_q[3:0] ^ ylo_q[7:4] ^ ylo_q[3:0];
  assign x_full  = {spi_byte[7:6], xlo_q};
  assign y_full  = {spi_byte[5:4], ylo_q};
  assign pkt_ok  = (csum == spi_byte[3:0]) && ({1'b0, x_full} < X_LIM) && ({1'b0, y_full} < Y_LIM);
  assign gap_inc = gap_q + 11'd1;

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    b0_d      = b0_q;
    xlo_d     = xlo_q;
    ylo_d     = ylo_q;
    brush_d   = brush_q;
    color_d   = color_q;
    x_d       = x_q;
    y_d       = y_q;
    ready_d   = 1'b0;
    pkt_err_d = 1'b0;

    if (state_q == IDLE) begin
      gap_d = 11'd0;
      if (byte_valid && (spi_byte[7:5] == SYNC)) begin
        b0_d    = spi_byte;
        state_d = HDR;
      end
    end else if (byte_valid) begin
      gap_d = 11'd0;
      case (state_q)
        HDR: begin
          xlo_d   = spi_byte;
          state_d = XLO;
        end
        XLO: begin
          ylo_d   = spi_byte;
          state_d = YLO;
        end
        default: begin
          state_d = IDLE;
          if (pkt_ok) begin
            brush_d = b0_q[4];
            color_d = b0_q[2:0];
            x_d     = x_full;
            y_d     = y_full;
            ready_d = 1'b1;
          end else begin
            pkt_err_d = 1'b1;
          end
        end
      endcase
    end else if (gap_inc == TO_LIM) begin
      // Stalled packet: silently abandon it.
      state_d = IDLE;
      gap_d   = 11'd0;
    end else begin
      gap_d = gap_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gap_q     <= 11'd0;
      b0_q      <= 8'd0;
      xlo_q     <= 8'd0;
      ylo_q     <= 8'd0;
      brush_q   <= 1'b0;
      color_q   <= 3'd0;
      x_q       <= 10'd0;
      y_q       <= 10'd0;
      ready_q   <= 1'b0;
      pkt_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      b0_q      <= b0_d;
      xlo_q     <= xlo_d;
      ylo_q     <= ylo_d;
      brush_q   <= brush_d;
      color_q   <= color_d;
      x_q       <= x_d;
      y_q       <= y_d;
      ready_q   <= ready_d;
      pkt_err_q <= pkt_err_d;
    end
  end

  assign brush    = brush_q;
  assign newColor = color_q;
  assign x        = x_q;
  assign y        = y_q;
  assign ready    = ready_q;
  assign pkt_err  = pkt_err_q;

endmodule

// File: tb/tb_spi_packet_decode.sv
// tb/tb_spi_packet_decode.sv - scoreboard bench for spi_packet_decode
// Expected pulses are queued as bytes are sent; a monitor queues observed pulses for comparison.
module tb_spi_packet_decode;

  logic       clk;
  logic       reset_n;
  logic       byte_valid;
  logic [7:0] spi_byte;
  logic       brush;
  logic [2:0] newColor;
  logic [9:0] x;
  logic [9:0] y;
  logic       ready;
  logic       pkt_err;

  spi_packet_decode dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .byte_valid(byte_valid),
    .spi_byte  (spi_byte),
    .brush     (brush),
    .newColor  (newColor),
    .x         (x),
    .y         (y),
    .ready     (ready),
    .pkt_err   (pkt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       err;
    logic       rdy;
    logic       br;
    logic [2:0] col;
    logic [9:0] px;
    logic [9:0] py;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic       m_brush;
  logic [2:0] m_color;
  logic [9:0] m_x;
  logic [9:0] m_y;

  always @(negedge clk) begin
    if (ready || pkt_err) begin
      ev_t ev;
      ev.err = pkt_err;
      ev.rdy = ready;
      ev.br  = brush;
      ev.col = newColor;
      ev.px  = x;
      ev.py  = y;
      obs_q.push_back(ev);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    assert (got === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    spi_byte   = b;
    @(negedge clk);
    byte_valid = 1'b0;
    spi_byte   = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input logic ok);
    ev_t ev;
    ev.err = !ok;
    ev.rdy = ok;
    ev.br  = m_brush;
    ev.col = m_color;
    ev.px  = m_x;
    ev.py  = m_y;
    exp_q.push_back(ev);
  endtask

  task automatic send_pkt(input logic br, input logic [2:0] col, input logic [9:0] px,
                          input logic [9:0] py, input logic [3:0] cflip);
    logic [7:0] b0, b1, b2, b3;
    logic [3:0] cs;
    logic       ok;
    b0 = {3'b101, br, col[1], col};
    b1 = px[7:0];
    b2 = py[7:0];
    cs = b0[7:4] ^ b0[3:0] ^ b1[7:4] ^ b1[3:0] ^ b2[7:4] ^ b2[3:0];
    b3 = {px[9:8], py[9:8], cs ^ cflip};
    ok = (cflip == 4'd0) && (px < 10'd640) && (py < 10'd480);
    if (ok) begin
      m_brush = br;
      m_color = col;
      m_x     = px;
      m_y     = py;
    end
    push_exp(ok);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
  endtask

  task automatic send_ref(input logic [7:0] b3);
    logic ok;
    ok = (b3 == 8'h0D);
    if (ok) begin
      m_brush = 1'b1;
      m_color = 3'd5;
      m_x     = 10'd100;
      m_y     = 10'd50;
    end
    push_exp(ok);
    send_byte(8'hB5);
    send_byte(8'h64);
    send_byte(8'h32);
    send_byte(b3);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".brush"}, 32'(brush), 32'(m_brush));
    chk({tag, ".color"}, 32'(newColor), 32'(m_color));
    chk({tag, ".x"}, 32'(x), 32'(m_x));
    chk({tag, ".y"}, 32'(y), 32'(m_y));
  endtask

  task automatic drain(input string tag);
    ev_t e, o;
    idle(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        chk({tag, ".missing_pulse"}, 32'd0, 32'd1);
      end else begin
        o = obs_q.pop_front();
        chk({tag, ".pkt_err"}, 32'(o.err), 32'(e.err));
        chk({tag, ".ready"}, 32'(o.rdy), 32'(e.rdy));
        chk({tag, ".ev_brush"}, 32'(o.br), 32'(e.br));
        chk({tag, ".ev_color"}, 32'(o.col), 32'(e.col));
        chk({tag, ".ev_x"}, 32'(o.px), 32'(e.px));
        chk({tag, ".ev_y"}, 32'(o.py), 32'(e.py));
      end
    end
    chk({tag, ".extra_pulses"}, 32'(obs_q.size()), 32'd0);
    obs_q.delete();
    check_outputs(tag);
  endtask

  initial begin
    m_brush    = 1'b0;
    m_color    = 3'd0;
    m_x        = 10'd0;
    m_y        = 10'd0;
    reset_n    = 1'b0;
    byte_valid = 1'b0;
    spi_byte   = 8'h00;
    idle(3);
    reset_n = 1'b1;
    chk("reset.ready", 32'(ready), 32'd0);
    chk("reset.pkt_err", 32'(pkt_err), 32'd0);
    check_outputs("reset");

    send_ref(8'h0D);
    drain("valid_ref");

    send_ref(8'h0E);
    drain("bad_csum");

    send_pkt(1'b0, 3'd2, 10'd700, 10'd10, 4'd0);
    drain("x_700");

    send_pkt(1'b0, 3'd3, 10'd639, 10'd479, 4'd0);
    drain("max_corner");

    send_pkt(1'b1, 3'd6, 10'd640, 10'd0, 4'd0);
    send_pkt(1'b1, 3'd6, 10'd0, 10'd480, 4'd0);
    drain("edge_reject");

    send_byte(8'h00);
    send_byte(8'hFF);
    send_ref(8'h0D);
    drain("garbage");

    send_pkt(1'b0, 3'd1, 10'd1, 10'd2, 4'd0);
    send_pkt(1'b1, 3'd7, 10'd513, 10'd257, 4'd0);
    send_pkt(1'b0, 3'd4, 10'd3, 10'd4, 4'd8);
    send_pkt(1'b1, 3'd0, 10'd300, 10'd200, 4'd0);
    drain("back_to_back");

    send_byte(8'hB5);
    send_byte(8'h64);
    idle(1024);
    send_ref(8'h0D);
    drain("timeout");

    send_pkt(1'b0, 3'd2, 10'd20, 10'd30, 4'd0);
    drain("pre_gap");
    push_exp(1'b1);
    m_brush = 1'b1;
    m_color = 3'd5;
    m_x     = 10'd100;
    m_y     = 10'd50;
    exp_q.delete();
    push_exp(1'b1);
    send_byte(8'hB5);
    idle(1023);
    send_byte(8'h64);
    send_byte(8'h32);
    send_byte(8'h0D);
    drain("gap_byte_wins");

    send_byte(8'hB5);
    send_byte(8'h64);
    reset_n    = 1'b0;
    byte_valid = 1'b1;
    spi_byte   = 8'h32;
    @(negedge clk);
    reset_n    = 1'b1;
    byte_valid = 1'b0;
    spi_byte   = 8'h00;
    m_brush = 1'b0;
    m_color = 3'd0;
    m_x     = 10'd0;
    m_y     = 10'd0;
    obs_q.delete();
    chk("midreset.ready", 32'(ready), 32'd0);
    chk("midreset.pkt_err", 32'(pkt_err), 32'd0);
    check_outputs("midreset");
    send_ref(8'h0D);
    drain("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_packet_decode.md
SPI_PACKET_DECODE -- requirements
Module: spi_packet_decode

Interface
REQ-001 Parameter X_MAX, default 640, exclusive upper bound on accepted x.
REQ-002 Parameter Y_MAX, default 480, exclusive upper bound on accepted y.
REQ-003 Parameter TIMEOUT, default 1024, idle-cycle limit between bytes of one packet.
REQ-004 Port clk, input, 1, pixel clock; all state SHALL update on its rising edge only.
REQ-005 Port reset_n, input, 1, synchronous active-low reset.
REQ-006 Port byte_valid, input, 1, one-cycle strobe marking spi_byte as a new received byte.
REQ-007 Port spi_byte, input, 8, received SPI byte, valid only when byte_valid=1.
REQ-008 Port brush, output, 1, brush enable from the last accepted packet.
REQ-009 Port newColor, output, 3, colour code from the last accepted packet.
REQ-010 Port x, output, 10, pixel column from the last accepted packet.
REQ-011 Port y, output, 10, pixel row from the last accepted packet.
REQ-012 Port ready, output, 1, one-cycle pulse marking an update of brush/newColor/x/y.
REQ-013 Port pkt_err, output, 1, one-cycle pulse marking a rejected complete packet.

Function
REQ-014 Packet format SHALL be 4 bytes, B0..B3, in this order:
- B0: [7:5] sync, must be 3'b101; [4] brush; [3] reserved, ignored; [2:0] colour.
- B1: x[7:0].
- B2: y[7:0].
- B3: [7:6] x[9:8]; [5:4] y[9:8]; [3:0] checksum.
REQ-015 The checksum SHALL equal the XOR of the six nibbles of B0, B1 and B2.
REQ-016 The FSM SHALL have states IDLE, HDR, XLO and YLO.
- IDLE --B0 with valid sync--> HDR.
- HDR --byte--> XLO.
- XLO --byte--> YLO.
- YLO --byte, treated as B3--> IDLE.
REQ-017 In IDLE, a byte without sync 3'b101 SHALL be dropped silently: state stays IDLE, no pulse.
REQ-018 In HDR, XLO and YLO, every byte SHALL be taken as data, whatever its value; there is no resync on a sync pattern.
REQ-019 Partial fields SHALL be held in internal shadow registers; outputs SHALL NOT change before B3.
REQ-020 On the edge that samples B3, if the checksum matches, x<X_MAX and y<Y_MAX:
- brush, newColor, x and y SHALL load the shadow values on that same edge;
- ready SHALL be 1 for exactly the following cycle.
REQ-021 If the checksum or the range check fails at B3:
- outputs SHALL hold their previous values;
- pkt_err SHALL be 1 for exactly the following cycle;
- ready SHALL stay 0.
REQ-022 ready and pkt_err SHALL never both be 1, and each SHALL deassert after one cycle.
REQ-023 An 11-bit gap counter SHALL clear on every byte_valid and increment each cycle in HDR, XLO or YLO without byte_valid.
REQ-024 When the gap counter reaches TIMEOUT, the FSM SHALL return to IDLE, discard the partial packet and assert no pulse.
REQ-025 The gap counter SHALL hold at 0 in IDLE.
REQ-026 A byte_valid in the same cycle the timeout fires SHALL win: the byte is consumed and the timeout is ignored.
REQ-027 Back-to-back byte_valid on consecutive cycles SHALL be accepted with no bubble.
REQ-028 A new packet's B0 MAY arrive in the cycle that ready is high; no byte SHALL be lost.

Reset
REQ-029 While reset_n=0 at a rising edge, on that edge:
- state SHALL become IDLE;
- gap counter and shadow registers SHALL clear to 0;
- brush, newColor, x, y, ready and pkt_err SHALL become 0.
REQ-030 Reset during HDR, XLO or YLO SHALL discard the partial packet; the next B0 starts a new packet.
REQ-031 byte_valid SHALL be ignored on any edge where reset_n=0.

Verification
REQ-032 Valid packet: bytes 0xB5, 0x64, 0x32, 0x0D -> ready pulses once; brush=1, newColor=5, x=100, y=50.
REQ-033 Bad checksum: bytes 0xB5, 0x64, 0x32, 0x0E -> pkt_err pulses once; outputs unchanged from the prior packet.
REQ-034 Out of range: x=700 with correct checksum -> pkt_err pulses once; no ready.
REQ-035 Garbage then packet: 0x00, 0xFF, then the REQ-032 packet -> garbage bytes dropped; exactly one ready with the REQ-032 values.
REQ-036 Timeout: 0xB5, 0x64, then TIMEOUT idle cycles, then the REQ-032 packet -> no pulse for the partial packet; one ready for the new packet.
REQ-037 Reset mid-packet: reset_n=0 for one cycle after B1, then the full REQ-032 packet -> all outputs 0 after reset; one ready with the REQ-032 values.
